// File: rtl/divu_unit.sv
`default_nettype none
// ============================================================================
// Module      : divu_unit
// Description : Sequential radix-2 restoring divider for MIPS DIV/DIVU.
//               The result is {remainder, quotient}, and busy stalls HI/LO readers.
// Revision    : 1.0 - initial release
// ============================================================================
module divu_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut,
    output logic                 div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      rem_q, rem_d;
    logic [WIDTH-1:0]      quot_q, quot_d;
    logic [WIDTH-1:0]      dvsr_q, dvsr_d;
    logic                  qs_q, qs_d;
    logic                  rs_q, rs_d;
    logic                  dz_path_q, dz_path_d;
    logic [2*WIDTH-1:0]    data_out_q, data_out_d;
    logic                  div_zero_q, div_zero_d;

    logic [WIDTH:0]        w_rem_sh;
    logic [WIDTH:0]        w_trial;
    logic [WIDTH-1:0]      w_abs_a;
    logic [WIDTH-1:0]      w_abs_b;
    logic [WIDTH-1:0]      w_quot_fix;
    logic [WIDTH-1:0]      w_rem_fix;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        qs_d       = qs_q;
        rs_d       = rs_q;
        dz_path_d  = dz_path_q;
        data_out_d = data_out_q;
        div_zero_d = div_zero_q;

        // The dividend is held in quot and shifts into rem one bit per cycle.
        w_rem_sh   = {rem_q, quot_q[WIDTH-1]};
        w_trial    = w_rem_sh - {1'b0, dvsr_q};
        w_abs_a    = (is_signed && dataA[WIDTH-1]) ? -dataA : dataA;
        w_abs_b    = (is_signed && dataB[WIDTH-1]) ? -dataB : dataB;
        w_quot_fix = qs_q ? -quot_q : quot_q;
        w_rem_fix  = rs_q ? -rem_q  : rem_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dataB == '0) begin
                        // Zero divisor publishes immediately, then passes
                        // through FIX untouched so done lands two cycles out.
                        data_out_d = {dataA, {WIDTH{1'b1}}};
                        div_zero_d = 1'b1;
                        dz_path_d  = 1'b1;
                        state_d    = S_FIX;
                    end else begin
                        quot_d    = w_abs_a;
                        dvsr_d    = w_abs_b;
                        qs_d      = (dataA[WIDTH-1] ^ dataB[WIDTH-1]) & is_signed;
                        rs_d      = dataA[WIDTH-1] & is_signed;
                        rem_d     = '0;
                        cnt_d     = C_CNT_LAST;
                        dz_path_d = 1'b0;
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!w_trial[WIDTH]) begin
                    rem_d  = w_trial[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = w_rem_sh[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            S_FIX: begin
                if (!dz_path_q) begin
                    data_out_d = {w_rem_fix, w_quot_fix};
                    div_zero_d = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            qs_q       <= 1'b0;
            rs_q       <= 1'b0;
            dz_path_q  <= 1'b0;
            data_out_q <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvsr_q     <= dvsr_d;
            qs_q       <= qs_d;
            rs_q       <= rs_d;
            dz_path_q  <= dz_path_d;
            data_out_q <= data_out_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign dataOut  = data_out_q;
    assign div_zero = div_zero_q;

endmodule
`default_nettype wire
